// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline stage register between two CPU pipeline stages. Carries
//   one control bundle and one data bundle under a valid/ready handshake,
//   supports a synchronous flush, and forces control to zero in bubbles.
//
//   Optional feature macro: PIPE_SKID_EN
//     defined   : two entries (main M + skid S), registered in_ready = ~S.valid
//     undefined : single entry, in_ready = ~out_valid | out_ready
//
// Ports
//   CLK        clock, rising edge
//   RSTN       asynchronous active-low reset
//   flush      synchronous squash of held beats and the beat presented now
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle
//   in_ctrl    upstream control bundle  [CTRL_W]
//   in_data    upstream data bundle     [DATA_W]
//   out_valid  registered; beat held for downstream
//   out_ready  downstream accepts this cycle
//   out_ctrl   registered control, all-zero whenever out_valid=0
//   out_data   registered data, keeps its last value when out_valid=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e              state_q;
  logic                m_valid_q;
  logic [CTRL_W-1:0]   m_ctrl_q;
  logic [DATA_W-1:0]   m_data_q;
  logic                in_xfer;
  logic                out_xfer;

`ifdef PIPE_SKID_EN
  logic                s_valid_q;
  logic [CTRL_W-1:0]   s_ctrl_q;
  logic [DATA_W-1:0]   s_data_q;

  // Depends only on state, so out_ready never reaches in_ready.
  assign in_ready = ~s_valid_q;
`else
  assign in_ready = ~m_valid_q | out_ready;
`endif

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = m_valid_q & out_ready;

  assign out_valid = m_valid_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_EMPTY;
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
`ifdef PIPE_SKID_EN
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
`endif
    end else if (flush) begin
      // Data registers are left alone; only valid and control are squashed.
      // A beat leaving on this edge has already been taken downstream.
      state_q   <= ST_EMPTY;
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
`ifdef PIPE_SKID_EN
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_valid_q <= 1'b1;
            m_ctrl_q  <= in_ctrl;
            m_data_q  <= in_data;
            state_q   <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_xfer && in_xfer) begin
            m_ctrl_q <= in_ctrl;
            m_data_q <= in_data;
          end else if (out_xfer) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            state_q   <= ST_EMPTY;
          end
`ifdef PIPE_SKID_EN
          else if (in_xfer) begin
            // Downstream stalled while upstream pushed: park the newer beat.
            s_valid_q <= 1'b1;
            s_ctrl_q  <= in_ctrl;
            s_data_q  <= in_data;
            state_q   <= ST_SKID;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        ST_SKID: begin
          if (out_xfer) begin
            m_ctrl_q  <= s_ctrl_q;
            m_data_q  <= s_data_q;
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            state_q   <= ST_FULL;
          end
        end
`endif
        default: begin
          state_q   <= ST_EMPTY;
          m_valid_q <= 1'b0;
          m_ctrl_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 128;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RSTN;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RSTN(RSTN), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
  );

  always #5 CLK = ~CLK;

  // Reference model: the stage is a FIFO of accepted beats, oldest at head.
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  beat_t             q[$];
  logic [DATA_W-1:0] last_d;
  int                total = 0;
  int                bad   = 0;
  int                n55   = 0;
  int                n66   = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_rdy();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic check_outputs();
    logic              v;
    logic [CTRL_W-1:0] hc;
    logic [DATA_W-1:0] hd;
    v  = q.size() != 0;
    hc = '0;
    hd = last_d;
    if (v) begin
      hc = q[0].c;
      hd = q[0].d;
    end
    chk("out_valid", DATA_W'(out_valid), DATA_W'(v));
    chk("out_ctrl",  DATA_W'(out_ctrl),  DATA_W'(hc));
    chk("out_data",  out_data,           hd);
    chk("in_ready",  DATA_W'(in_ready),  DATA_W'(exp_rdy()));
  endtask

  // Called just after the rising edge, inputs still as they were at the edge.
  task automatic model_update();
    logic  outx, inx;
    beat_t b;
    outx = (q.size() != 0) && out_ready;
    inx  = in_valid && exp_rdy();
    if (out_valid && out_ready && out_data == DATA_W'(8'h55)) n55++;
    if (out_valid && out_ready && out_data == DATA_W'(8'h66)) n66++;
    if (outx) void'(q.pop_front());
    if (flush) q.delete();
    else if (inx) begin
      b.c = in_ctrl;
      b.d = in_data;
      q.push_back(b);
    end
    if (q.size() != 0) last_d = q[0].d;
  endtask

  task automatic step(input logic fl, input logic iv, input logic [CTRL_W-1:0] c,
                      input logic [DATA_W-1:0] d, input logic ordy);
    flush = fl; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    RSTN = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    last_d = '0;
    #1 RSTN = 1'b0;
    #2;
    chk("rst_valid", DATA_W'(out_valid), '0);
    chk("rst_ctrl",  DATA_W'(out_ctrl),  '0);
    chk("rst_data",  out_data,           '0);
    chk("rst_ready", DATA_W'(in_ready),  DATA_W'(1));
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); RSTN = 1'b1;
    @(posedge CLK); #1;

    // Stream of four beats at full throughput, then drain.
    step(1'b0, 1'b1, 8'h0F, 128'h11, 1'b1);
    step(1'b0, 1'b1, 8'h0F, 128'h22, 1'b1);
    step(1'b0, 1'b1, 8'h0F, 128'h33, 1'b1);
    step(1'b0, 1'b1, 8'h0F, 128'h44, 1'b1);
    idle(2);
    chk("drain_ctrl", DATA_W'(out_ctrl), '0);
    chk("drain_data", out_data, 128'h44);

    // Stall in FULL with 0x22 held; 0x33 presented during the stall.
    step(1'b0, 1'b1, 8'h0F, 128'h11, 1'b1);
    step(1'b0, 1'b1, 8'h0F, 128'h22, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h0F, 128'h33, 1'b0);
    chk("stall_data", out_data, 128'h22);
    // Skid build already holds 0x33; single-entry build still needs it offered.
    step(1'b0, !SKID, 8'h0F, 128'h33, 1'b1);
    idle(3);

    // Flush while full (SKID in the two-entry build) with 0x55 offered.
    step(1'b0, 1'b1, 8'h01, 128'h41, 1'b0);
    step(1'b0, 1'b1, 8'h02, 128'h42, 1'b0);
    step(1'b1, 1'b1, 8'h03, 128'h55, 1'b0);
    chk("flush_valid", DATA_W'(out_valid), '0);
    chk("flush_ctrl",  DATA_W'(out_ctrl),  '0);
    chk("flush_ready", DATA_W'(in_ready),  DATA_W'(1));
    idle(3);
    chk("n55", DATA_W'(n55), '0);

    // Flush coinciding with delivery of 0x66.
    step(1'b0, 1'b1, 8'h0C, 128'h66, 1'b1);
    step(1'b1, 1'b0, 8'h00, 128'h00, 1'b1);
    idle(2);
    chk("n66", DATA_W'(n66), DATA_W'(1));
    chk("flush66_valid", DATA_W'(out_valid), '0);

    // Asynchronous reset pulse between edges while holding ctrl 0xFF.
    step(1'b0, 1'b1, 8'hFF, 128'hABCD, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 RSTN = 1'b0;
    #1;
    chk("arst_valid", DATA_W'(out_valid), '0);
    chk("arst_ctrl",  DATA_W'(out_ctrl),  '0);
    chk("arst_data",  out_data,           '0);
    RSTN = 1'b1;
    q.delete();
    last_d = '0;
    @(posedge CLK); #1;

    // Random valid/ready/flush traffic.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7,
           CTRL_W'($urandom),
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 9) < 6);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
